// File: rtl/sram_fifo_prefetch_if.sv
// Signal bundle between the upstream BRAM FIFO, the prefetch output stage and the consumer.
// The slave modport is the prefetch stage; the master modport is its environment.
interface sram_fifo_prefetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush_i;
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_pop_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [1:0]            occupancy_o;

  modport slave (
    input  flush_i,
    input  fifo_empty_i,
    input  fifo_data_i,
    input  ready_i,
    output fifo_pop_o,
    output valid_o,
    output data_o,
    output occupancy_o
  );

  modport master (
    output flush_i,
    output fifo_empty_i,
    output fifo_data_i,
    output ready_i,
    input  fifo_pop_o,
    input  valid_o,
    input  data_o,
    input  occupancy_o
  );
endinterface

// File: rtl/sram_fifo_prefetch.sv
// Prefetch stage after the BRAM FIFO: hides the one-cycle read latency behind a
// 2-entry registered buffer and presents a valid/ready stream at full throughput.
module sram_fifo_prefetch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  sram_fifo_prefetch_if.slave bus
);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic                  inflight_q;
  logic                  flush_hold_q;

  logic [1:0] credits;
  logic       valid;
  logic       deq;
  logic       pop;

  // Credits cover both stored words and the word still on its way out of the BRAM.
  assign credits = count_q + {1'b0, inflight_q};
  assign valid   = (count_q != 2'd0);
  assign deq     = valid & bus.ready_i;

  // flush_hold covers the cycle where the upstream FIFO has not yet applied its flush.
  assign pop = rst_ni & ~bus.fifo_empty_i & ~bus.flush_i & ~flush_hold_q &
               ((credits < 2'd2) | ((credits == 2'd2) & deq));

  assign bus.fifo_pop_o  = pop;
  assign bus.valid_o     = valid;
  assign bus.data_o      = buf_q[rd_ptr_q];
  assign bus.occupancy_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      inflight_q   <= 1'b0;
      flush_hold_q <= 1'b0;
    end else begin
      flush_hold_q <= bus.flush_i;
      if (bus.flush_i) begin
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
        count_q    <= 2'd0;
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= pop;
        count_q    <= count_q + {1'b0, inflight_q} - {1'b0, deq};
        if (deq) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        // At count==2 a capture only happens alongside a dequeue, so it lands in the freed slot.
        if (inflight_q) begin
          buf_q[wr_ptr_q] <= bus.fifo_data_i;
          wr_ptr_q        <= ~wr_ptr_q;
        end
      end
    end
  end

  a_credits_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) credits <= 2'd2);
  a_no_pop_empty:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && bus.fifo_empty_i));

endmodule

// File: tb/tb_sram_fifo_prefetch.sv
// Bench for sram_fifo_prefetch: queue-based upstream FIFO, a word-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_sram_fifo_prefetch;
  localparam int DW = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  sram_fifo_prefetch_if #(.DATA_WIDTH(DW)) bus ();

  sram_fifo_prefetch #(.DATA_WIDTH(DW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            arr;
  } ent_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] up_q [$];
  logic [DW-1:0] pend [$];
  logic [DW-1:0] dlog [$];
  ent_t          mq   [$];
  logic          up_empty = 1'b1;
  logic [DW-1:0] up_data  = '0;

  logic pop_s = 1'b0, pop_exp_s = 1'b0, deq_s = 1'b0, flush_s = 1'b0, flush_d = 1'b0;
  logic saw55 = 1'b0;

  assign bus.fifo_empty_i = up_empty;
  assign bus.fifo_data_i  = up_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the word-level model.
  always @(negedge clk_i) begin
    int   n_arr;
    logic v_exp, deq_exp, pop_exp;
    if (!rst_ni) begin
      chk("rst_pop", bus.fifo_pop_o, 0);
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_data", bus.data_o, 0);
      chk("rst_occ", bus.occupancy_o, 0);
      pop_s = 1'b0; pop_exp_s = 1'b0; deq_s = 1'b0; flush_s = 1'b0;
    end else begin
      n_arr = 0;
      foreach (mq[i]) if (mq[i].arr <= cyc) n_arr++;
      v_exp   = (n_arr != 0);
      deq_exp = v_exp && bus.ready_i;
      pop_exp = !bus.fifo_empty_i && !bus.flush_i && !flush_d &&
                (mq.size() < 2 || (mq.size() == 2 && deq_exp));
      chk("pop", bus.fifo_pop_o, pop_exp);
      chk("pop_when_empty", bus.fifo_pop_o & bus.fifo_empty_i, 0);
      chk("valid", bus.valid_o, v_exp);
      chk("occupancy", bus.occupancy_o, n_arr);
      if (v_exp) chk("data", bus.data_o, mq[0].d);
      if (bus.valid_o && bus.ready_i) dlog.push_back(bus.data_o);
      if (bus.valid_o && bus.data_o == 32'h55) saw55 = 1'b1;
      pop_s     = bus.fifo_pop_o;
      pop_exp_s = pop_exp;
      deq_s     = deq_exp;
      flush_s   = bus.flush_i;
    end
  end

  // Model and upstream-FIFO update at the clock edge.
  always @(posedge clk_i) begin
    ent_t          e;
    logic [DW-1:0] w;
    if (!rst_ni) begin
      mq.delete();
      flush_d = 1'b0;
    end else begin
      if (flush_s) mq.delete();
      else begin
        if (deq_s && mq.size() != 0) void'(mq.pop_front());
        if (pop_exp_s && up_q.size() != 0) begin
          e.d   = up_q[0];
          e.arr = cyc + 2;
          mq.push_back(e);
        end
      end
      if (flush_d) up_q.delete();
      else if (pop_s && up_q.size() != 0) begin
        w = up_q.pop_front();
        up_data <= w;
      end
      flush_d = flush_s;
    end
    if (!flush_s && !flush_d)
      while (pend.size() != 0) up_q.push_back(pend.pop_front());
    up_empty <= (up_q.size() == 0);
    cyc++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_dlog(input int n, input int budget);
    int k = 0;
    while (dlog.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("delivered_count", dlog.size(), n);
  endtask

  logic          cs_pop   [7] = '{1, 1, 1, 1, 0, 0, 0};
  logic          cs_valid [7] = '{0, 0, 1, 1, 1, 1, 0};
  logic [DW-1:0] cs_data  [7] = '{0, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0};

  initial begin
    bus.ready_i = 1'b1;
    bus.flush_i = 1'b0;
    for (int i = 0; i < 4; i++) pend.push_back(32'hA0 + i);

    // Reset held with a non-empty FIFO, then cold start.
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #2;
    for (int k = 0; k < 7; k++) begin
      chk("cold_pop", bus.fifo_pop_o, cs_pop[k]);
      chk("cold_valid", bus.valid_o, cs_valid[k]);
      if (cs_valid[k]) chk("cold_data", bus.data_o, cs_data[k]);
      @(posedge clk_i);
      #3;
    end
    chk("cold_count", dlog.size(), 4);
    for (int i = 0; i < 4; i++) chk("cold_order", dlog[i], 32'hA0 + i);

    // Backpressure.
    dlog.delete();
    for (int i = 0; i < 8; i++) pend.push_back(32'h10 + i);
    tick(); tick(); tick();
    bus.ready_i = 1'b0;
    #2;
    chk("bp_first_occ", bus.occupancy_o, 1);
    chk("bp_first_data", bus.data_o, 32'h10);
    for (int k = 0; k < 5; k++) begin
      tick();
      #2;
      chk("bp_occ_full", bus.occupancy_o, 2);
      chk("bp_pop_full", bus.fifo_pop_o, 0);
      chk("bp_data_hold", bus.data_o, 32'h10);
    end
    tick();
    bus.ready_i = 1'b1;
    wait_dlog(8, 40);
    for (int i = 0; i < 8; i++) chk("bp_order", dlog[i], 32'h10 + i);

    // Full buffer with a single-cycle ready pulse.
    bus.ready_i = 1'b0;
    dlog.delete();
    for (int i = 0; i < 6; i++) pend.push_back(32'h30 + i);
    for (int k = 0; k < 20; k++) begin
      tick();
      #2;
      if (bus.occupancy_o == 2'd2) break;
    end
    chk("fb_prime", bus.occupancy_o, 2);
    tick();
    bus.ready_i = 1'b1;
    #2;
    chk("fb_pulse_pop", bus.fifo_pop_o, 1);
    chk("fb_pulse_occ", bus.occupancy_o, 2);
    chk("fb_pulse_data", bus.data_o, 32'h30);
    tick();
    bus.ready_i = 1'b0;
    #2;
    chk("fb_after_occ", bus.occupancy_o, 1);
    chk("fb_after_pop", bus.fifo_pop_o, 0);
    chk("fb_after_data", bus.data_o, 32'h31);
    tick();
    #2;
    chk("fb_refill_occ", bus.occupancy_o, 2);
    tick();
    bus.ready_i = 1'b1;
    wait_dlog(6, 40);
    for (int i = 0; i < 6; i++) chk("fb_order", dlog[i], 32'h30 + i);

    // Flush with a word in flight.
    dlog.delete();
    saw55 = 1'b0;
    pend.push_back(32'h55);
    tick();
    #2;
    chk("fl_pop_55", bus.fifo_pop_o, 1);
    tick();
    bus.flush_i = 1'b1;
    pend.push_back(32'h77);
    #2;
    chk("fl_pop_flush", bus.fifo_pop_o, 0);
    chk("fl_valid_flush", bus.valid_o, 0);
    tick();
    bus.flush_i = 1'b0;
    #2;
    chk("fl_pop_hold", bus.fifo_pop_o, 0);
    chk("fl_valid_hold", bus.valid_o, 0);
    wait_dlog(1, 20);
    chk("fl_first_word", dlog[0], 32'h77);
    chk("fl_no_55", saw55, 0);

    // Reset in the middle of a transfer.
    for (int i = 0; i < 8; i++) pend.push_back(32'h80 + i);
    repeat (4) tick();
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    repeat (30) tick();

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      tick();
      bus.ready_i = ($urandom_range(0, 99) < 70);
      bus.flush_i = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 45 && (pend.size() + up_q.size()) < 12)
        pend.push_back($urandom);
    end
    tick();
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (40) tick();
    #2;
    chk("drain_occ", bus.occupancy_o, 0);
    chk("drain_valid", bus.valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
